// File: rtl/spi_master.sv
// SPI master, CPHA=0, MSB first, SCLK derived from clk by p_clk_div.
// Ports: clk/rst, ip_data_out/ip_data_count/i_start in; op_data_in/o_data_valid/o_busy out;
// or_sclk/or_mosi/or_cs_n/i_miso are the SPI pins.
module spi_master #(
  parameter int p_data_buffer_length  = 32,
  parameter int p_width_buffer_length = $clog2(p_data_buffer_length) + 1,
  parameter bit p_cpol                = 1'b0,
  parameter int p_clk_div             = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [p_data_buffer_length-1:0]  ip_data_out,
  input  logic [p_width_buffer_length-1:0] ip_data_count,
  input  logic                             i_start,
  output logic [p_data_buffer_length-1:0]  op_data_in,
  output logic                             o_data_valid,
  output logic                             o_busy,
  output logic                             or_sclk,
  output logic                             or_mosi,
  output logic                             or_cs_n,
  input  logic                             i_miso
);

  localparam int DW   = p_data_buffer_length;
  localparam int CW   = p_width_buffer_length;
  localparam int DIVW = $clog2(p_clk_div);

  localparam logic [CW-1:0]   NMAX    = CW'(DW);
  localparam logic [DIVW-1:0] DIV_MAX = DIVW'(p_clk_div - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_DONE
  } state_t;

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [DW-1:0]   tx_sr;
  logic [DW-1:0]   rx_sr;
  logic [CW-1:0]   n_bits;
  logic [CW-1:0]   bit_cnt;

  logic            tick;
  logic            trailing;
  logic [CW-1:0]   n_req;
  logic [DW-1:0]   tx_load;
  logic [DW-1:0]   rx_mask;

  always_comb begin
    tick     = (div_cnt == '0);
    // sclk currently away from idle: the next toggle returns it to idle
    trailing = (or_sclk != p_cpol);
    n_req    = (ip_data_count > NMAX) ? NMAX : ip_data_count;
    // left-align the used bits so MOSI always comes from the MSB
    tx_load  = ip_data_out << (NMAX - n_req);
    rx_mask  = {DW{1'b1}} >> (NMAX - n_bits);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      div_cnt      <= DIV_MAX;
      tx_sr        <= '0;
      rx_sr        <= '0;
      n_bits       <= '0;
      bit_cnt      <= '0;
      op_data_in   <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      or_sclk      <= p_cpol;
      or_mosi      <= 1'b0;
      or_cs_n      <= 1'b1;
    end else begin
      o_data_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          div_cnt <= DIV_MAX;
          if (i_start && (ip_data_count != '0)) begin
            tx_sr   <= tx_load;
            rx_sr   <= '0;
            n_bits  <= n_req;
            bit_cnt <= n_req;
            or_cs_n <= 1'b0;
            or_mosi <= tx_load[DW-1];
            o_busy  <= 1'b1;
            state   <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (tick) begin
            div_cnt <= DIV_MAX;
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            div_cnt <= DIV_MAX;
            or_sclk <= ~or_sclk;
            if (trailing) begin
              // miso is taken in the same cycle the edge is issued
              rx_sr   <= {rx_sr[DW-2:0], i_miso};
              tx_sr   <= tx_sr << 1;
              or_mosi <= tx_sr[DW-2];
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == CW'(1)) begin
                state <= S_TRAIL;
              end
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            div_cnt <= DIV_MAX;
            o_busy  <= 1'b0;
            or_cs_n <= 1'b1;
            or_mosi <= 1'b0;
            state   <= S_DONE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_DONE: begin
          div_cnt      <= DIV_MAX;
          op_data_in   <= rx_sr & rx_mask;
          o_data_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: cpol=0 and cpol=1 instances,
// loopback and a small CPHA=0 slave model on the cpol=0 side.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] d0_data = '0, d1_data = '0;
  logic [5:0]  d0_cnt = '0, d1_cnt = '0;
  logic        d0_start = 1'b0, d1_start = 1'b0;
  logic [31:0] d0_rx, d1_rx;
  logic        d0_valid, d1_valid;
  logic        d0_busy, d1_busy;
  logic        d0_sclk, d1_sclk;
  logic        d0_mosi, d1_mosi;
  logic        d0_cs_n, d1_cs_n;
  logic        d0_miso, d1_miso;

  logic        loop0 = 1'b1;
  logic [7:0]  slv_word = 8'h3C;
  logic [7:0]  slv_tx = '0;
  logic [31:0] slv_rx = '0;
  int          e0 = 0, e1 = 0, v0 = 0, v1 = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  assign d0_miso = loop0 ? d0_mosi : slv_tx[7];
  assign d1_miso = d1_mosi;

  spi_master #(.p_cpol(1'b0), .p_clk_div(4)) u0 (
    .clk(clk), .rst(rst),
    .ip_data_out(d0_data), .ip_data_count(d0_cnt),
    .i_start(d0_start), .op_data_in(d0_rx),
    .o_data_valid(d0_valid), .o_busy(d0_busy),
    .or_sclk(d0_sclk), .or_mosi(d0_mosi),
    .or_cs_n(d0_cs_n), .i_miso(d0_miso)
  );

  spi_master #(.p_cpol(1'b1), .p_clk_div(4)) u1 (
    .clk(clk), .rst(rst),
    .ip_data_out(d1_data), .ip_data_count(d1_cnt),
    .i_start(d1_start), .op_data_in(d1_rx),
    .o_data_valid(d1_valid), .o_busy(d1_busy),
    .or_sclk(d1_sclk), .or_mosi(d1_mosi),
    .or_cs_n(d1_cs_n), .i_miso(d1_miso)
  );

  // CPHA=0 slave model: first bit valid at cs_n fall,
  // capture on leading edge, shift on trailing edge
  always @(negedge d0_cs_n) slv_tx = slv_word;
  always @(posedge d0_sclk)
    if (!d0_cs_n) slv_rx = {slv_rx[30:0], d0_mosi};
  always @(negedge d0_sclk)
    if (!d0_cs_n) slv_tx = {slv_tx[6:0], 1'b0};

  always @(posedge d0_sclk) e0++;
  always @(negedge d1_sclk) e1++;
  always @(posedge clk) begin
    if (d0_valid) v0++;
    if (d1_valid) v1++;
  end

  typedef struct {
    bit          sel;
    bit          loop;
    logic [31:0] data;
    logic [5:0]  cnt;
    logic [31:0] exp_rx;
    logic [31:0] exp_tx;
    int          exp_n;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(bit s, bit l, logic [31:0] d,
                              logic [5:0] c, logic [31:0] r,
                              logic [31:0] t, int n);
    vec_t v;
    v.sel = s; v.loop = l; v.data = d; v.cnt = c;
    v.exp_rx = r; v.exp_tx = t; v.exp_n = n;
    v.exp_cyc = 1 + (2 * n + 2) * 4;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output logic [31:0] got,
                     output int cyc, output int bsy);
    @(negedge clk);
    loop0 = v.loop;
    slv_rx = '0;
    e0 = 0; e1 = 0; v0 = 0; v1 = 0;
    if (!v.sel) begin
      d0_data = v.data; d0_cnt = v.cnt; d0_start = 1'b1;
    end else begin
      d1_data = v.data; d1_cnt = v.cnt; d1_start = 1'b1;
    end
    @(posedge clk); #1;
    d0_start = 1'b0; d1_start = 1'b0;
    bsy = (v.sel ? d1_busy : d0_busy) ? 1 : 0;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (v.sel ? d1_busy : d0_busy) bsy++;
      if (v.sel ? d1_valid : d0_valid) break;
    end
    got = v.sel ? d1_rx : d0_rx;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] got;
    int cyc, bsy, flag;

    tbl[0] = mk(0, 1, 32'h000000A5, 6'd8,  32'h000000A5, 32'h000000A5, 8);
    tbl[1] = mk(0, 1, 32'h12345678, 6'd12, 32'h00000678, 32'h00000678, 12);
    tbl[2] = mk(0, 1, 32'h00000001, 6'd1,  32'h00000001, 32'h00000001, 1);
    tbl[3] = mk(0, 1, 32'hFFFFFFFF, 6'd40, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
    tbl[4] = mk(1, 1, 32'hDEADBEEF, 6'd32, 32'hDEADBEEF, 32'h0, 32);
    tbl[5] = mk(1, 1, 32'h00000006, 6'd3,  32'h00000006, 32'h0, 3);
    tbl[6] = mk(0, 0, 32'h000000C3, 6'd8,  32'h0000003C, 32'h000000C3, 8);

    #12;
    chk("rst_cs_n", {31'b0, d0_cs_n}, 32'd1);
    chk("rst_sclk0", {31'b0, d0_sclk}, 32'd0);
    chk("rst_sclk1", {31'b0, d1_sclk}, 32'd1);
    chk("rst_busy", {31'b0, d0_busy}, 32'd0);
    chk("rst_valid", {31'b0, d0_valid}, 32'd0);
    chk("rst_mosi", {31'b0, d0_mosi}, 32'd0);
    chk("rst_data", d0_rx, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i], got, cyc, bsy);
      chk($sformatf("v%0d_rx", i), got, tbl[i].exp_rx);
      chk($sformatf("v%0d_cyc", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("v%0d_busy", i), bsy, tbl[i].exp_cyc - 1);
      chk($sformatf("v%0d_edges", i),
          tbl[i].sel ? e1 : e0, tbl[i].exp_n);
      chk($sformatf("v%0d_pulses", i),
          tbl[i].sel ? v1 : v0, 32'd1);
      chk($sformatf("v%0d_cs_n", i),
          {31'b0, tbl[i].sel ? d1_cs_n : d0_cs_n}, 32'd1);
      chk($sformatf("v%0d_idle", i),
          {31'b0, tbl[i].sel ? d1_sclk : d0_sclk},
          {31'b0, tbl[i].sel});
      if (!tbl[i].sel)
        chk($sformatf("v%0d_mosi", i), slv_rx, tbl[i].exp_tx);
    end

    // count of zero must not start anything
    @(negedge clk);
    e0 = 0; v0 = 0; flag = 0;
    d0_data = 32'hFFFFFFFF; d0_cnt = 6'd0; d0_start = 1'b1;
    @(negedge clk);
    d0_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!d0_cs_n || d0_busy) flag++;
    end
    chk("cnt0_activity", flag, 32'd0);
    chk("cnt0_edges", e0, 32'd0);
    chk("cnt0_valid", v0, 32'd0);

    // second start mid-SHIFT with new data: ignored
    @(negedge clk);
    loop0 = 1'b1; e0 = 0; v0 = 0; slv_rx = '0;
    d0_data = 32'h5A; d0_cnt = 6'd8; d0_start = 1'b1;
    @(negedge clk);
    d0_start = 1'b0;
    repeat (30) @(negedge clk);
    d0_data = 32'hFF; d0_cnt = 6'd4; d0_start = 1'b1;
    @(negedge clk);
    d0_start = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_pulses", v0, 32'd1);
    chk("mid_rx", d0_rx, 32'h5A);
    chk("mid_edges", e0, 32'd8);
    chk("mid_mosi", slv_rx, 32'h5A);

    // reset around bit 3 of 8
    @(negedge clk);
    v0 = 0;
    d0_data = 32'hA5; d0_cnt = 6'd8; d0_start = 1'b1;
    @(negedge clk);
    d0_start = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_rst_busy", {31'b0, d0_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ab_cs_n", {31'b0, d0_cs_n}, 32'd1);
    chk("ab_sclk", {31'b0, d0_sclk}, 32'd0);
    chk("ab_busy", {31'b0, d0_busy}, 32'd0);
    chk("ab_data", d0_rx, 32'd0);
    repeat (10) @(negedge clk);
    chk("ab_valid", v0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run(mk(0, 1, 32'h96, 6'd8, 32'h96, 32'h96, 8), got, cyc, bsy);
    chk("post_rx", got, 32'h96);
    chk("post_cyc", cyc, 32'd73);
    chk("post_pulses", v0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
